chacha_keystream_ctrl: RTL and testbench

//  Hardware initiator for chacha_core. Latches key/iv/start counter, runs the per-block

---
 rtl/chacha_pkg.sv | 21 ++
 rtl/chacha_keystream_ctrl_if.sv | 10 +
 rtl/chacha_ks_serializer.sv | 59 +++++
 rtl/chacha_keystream_ctrl.sv | 154 +++++++++++++++
 tb/tb_chacha_keystream_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/chacha_pkg.sv
// Shared widths, FSM encoding and the latched core configuration for the keystream controller.
package chacha_pkg;
    localparam int BLOCK_W  = 512;
    localparam int KS_WORDS = 16;
    localparam int CTR_W    = 64;
    localparam int KEY_W    = 256;
    localparam int IV_W     = 64;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_NEXT  = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef struct packed {
        logic [KEY_W-1:0] key;
        logic [IV_W-1:0]  iv;
        logic [CTR_W-1:0] ctr;
    } core_cfg_t;
endpackage

// File: rtl/chacha_keystream_ctrl_if.sv
// Keystream word stream: master produces words, slave returns ks_ready.
interface chacha_keystream_ctrl_if #(parameter int WORD_W = 32);
    logic [WORD_W-1:0] ks_word;
    logic              ks_valid;
    logic              ks_ready;
    logic              ks_last;

    modport master (output ks_word, ks_valid, ks_last, input ks_ready);
    modport slave  (input ks_word, ks_valid, ks_last, output ks_ready);
endinterface

// File: rtl/chacha_ks_serializer.sv
// Holds one 512-bit block and shifts it out MSW first as 16 registered words.
// Latency: load -> word_vld next cycle; word_rdy low freezes the current word.
module chacha_ks_serializer
    import chacha_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic [BLOCK_W-1:0] load_dat,
    output logic               free,
    output logic [WORD_W-1:0]  word_dat,
    output logic               word_vld,
    input  logic               word_rdy,
    output logic               word_last
);
    localparam int CNT_W = $clog2(KS_WORDS);

    logic [BLOCK_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               vld_q, vld_d;
    logic               xfer;

    assign xfer      = vld_q & word_rdy;
    assign word_last = vld_q & (cnt_q == CNT_W'(KS_WORDS - 1));
    // Free on the cycle the final word leaves so a waiting block can follow without a bubble.
    assign free      = ~vld_q | (xfer & word_last);
    assign word_dat  = buf_q[BLOCK_W-1 -: WORD_W];
    assign word_vld  = vld_q;

    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        vld_d = vld_q;
        if (xfer) begin
            buf_d = buf_q << WORD_W;
            cnt_d = cnt_q + CNT_W'(1);
            if (word_last) vld_d = 1'b0;
        end
        if (load) begin
            buf_d = load_dat;
            cnt_d = '0;
            vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q <= '0;
            cnt_q <= '0;
            vld_q <= 1'b0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
            vld_q <= vld_d;
        end
    end
endmodule

// File: rtl/chacha_keystream_ctrl.sv
// Drives chacha_core init/next per block, auto-increments ctr and streams 16 words per block.
// Latency start->core_init 1, core valid->first word 1; ks_ready low stalls stream (and core when buffers full).
// CHACHA_KS_PREFETCH_EN: staging buffer lets the next block be fetched while the current one drains.
module chacha_keystream_ctrl
    import chacha_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int NBLK_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [KEY_W-1:0]       key,
    input  logic [IV_W-1:0]        iv,
    input  logic [CTR_W-1:0]       ctr_start,
    input  logic [NBLK_W-1:0]      num_blocks,
    chacha_keystream_ctrl_if.master ks,
    output logic                   busy,
    output logic                   done,
    output logic                   core_init,
    output logic                   core_next,
    output logic [KEY_W-1:0]       core_key,
    output logic [IV_W-1:0]        core_iv,
    output logic [CTR_W-1:0]       core_ctr,
    input  logic                   core_ready,
    input  logic [BLOCK_W-1:0]     core_data_out,
    input  logic                   core_data_out_valid
);
    logic [2:0]         state_q, state_d;
    core_cfg_t          cfg_q, cfg_d;
    logic [NBLK_W-1:0]  left_q, left_d;     // blocks not yet fully streamed
    logic               ser_load, ser_free, ser_last, ser_vld, blk_end;
    logic [BLOCK_W-1:0] ser_dat;
`ifdef CHACHA_KS_PREFETCH_EN
    logic [BLOCK_W-1:0] stage_q, stage_d;
    logic               stage_vld_q, stage_vld_d;
    logic [NBLK_W-1:0]  req_q, req_d;       // blocks not yet captured from the core
`endif

    chacha_ks_serializer #(.WORD_W(WORD_W)) u_ser (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (ser_load),
        .load_dat  (ser_dat),
        .free      (ser_free),
        .word_dat  (ks.ks_word),
        .word_vld  (ser_vld),
        .word_rdy  (ks.ks_ready),
        .word_last (ser_last)
    );

    assign blk_end     = ser_vld & ks.ks_ready & ser_last;
    assign ks.ks_valid = ser_vld;
    assign ks.ks_last  = ser_last & (left_q == NBLK_W'(1));
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign core_init   = (state_q == ST_INIT) & core_ready;
    assign core_next   = (state_q == ST_NEXT) & core_ready;
    assign core_key    = cfg_q.key;
    assign core_iv     = cfg_q.iv;
    assign core_ctr    = cfg_q.ctr;

    always_comb begin
        state_d  = state_q;
        cfg_d    = cfg_q;
        left_d   = left_q;
        ser_load = 1'b0;
        ser_dat  = core_data_out;
`ifdef CHACHA_KS_PREFETCH_EN
        stage_d     = stage_q;
        stage_vld_d = stage_vld_q;
        req_d       = req_q;
        if (stage_vld_q && ser_free) begin
            ser_load    = 1'b1;
            ser_dat     = stage_q;
            stage_vld_d = 1'b0;
        end
        if (blk_end) left_d = left_q - NBLK_W'(1);
`endif
        case (state_q)
            ST_IDLE: if (start) begin
                cfg_d.key = key;
                cfg_d.iv  = iv;
                cfg_d.ctr = ctr_start;
                left_d    = num_blocks;
`ifdef CHACHA_KS_PREFETCH_EN
                req_d     = num_blocks;
`endif
                state_d   = (num_blocks == '0) ? ST_DONE : ST_INIT;
            end
            ST_INIT: if (core_ready) state_d = ST_NEXT;
            ST_NEXT: if (core_ready) state_d = ST_WAIT;
`ifdef CHACHA_KS_PREFETCH_EN
            // Stage is always empty here: INIT is only entered once it has moved on.
            ST_WAIT: if (core_data_out_valid) begin
                req_d   = req_q - NBLK_W'(1);
                state_d = ST_DRAIN;
                if (ser_free) begin
                    ser_load = 1'b1;
                end else begin
                    stage_d     = core_data_out;
                    stage_vld_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (blk_end && left_q == NBLK_W'(1)) begin
                    state_d = ST_DONE;
                end else if (req_q != '0 && !stage_vld_q) begin
                    cfg_d.ctr = cfg_q.ctr + CTR_W'(1);
                    state_d   = ST_INIT;
                end
            end
`else
            ST_WAIT: if (core_data_out_valid && ser_free) begin
                ser_load = 1'b1;
                state_d  = ST_DRAIN;
            end
            ST_DRAIN: if (blk_end) begin
                if (left_q == NBLK_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    cfg_d.ctr = cfg_q.ctr + CTR_W'(1);
                    left_d    = left_q - NBLK_W'(1);
                    state_d   = ST_INIT;
                end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            left_q  <= '0;
`ifdef CHACHA_KS_PREFETCH_EN
            stage_q     <= '0;
            stage_vld_q <= 1'b0;
            req_q       <= '0;
`endif
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            left_q  <= left_d;
`ifdef CHACHA_KS_PREFETCH_EN
            stage_q     <= stage_d;
            stage_vld_q <= stage_vld_d;
            req_q       <= req_d;
`endif
        end
    end
endmodule

// File: tb/tb_chacha_keystream_ctrl.sv
// Directed bench for chacha_keystream_ctrl with a behavioural chacha_core stand-in.
module tb_chacha_keystream_ctrl;
    logic         clk, reset_n, start;
    logic [255:0] key, core_key;
    logic [63:0]  iv, ctr_start, core_iv, core_ctr;
    logic [15:0]  num_blocks;
    logic         busy, done, core_init, core_next, core_ready, core_data_out_valid;
    logic [511:0] core_data_out;

    chacha_keystream_ctrl_if ks ();

    chacha_keystream_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .key(key), .iv(iv),
        .ctr_start(ctr_start), .num_blocks(num_blocks), .ks(ks), .busy(busy), .done(done),
        .core_init(core_init), .core_next(core_next), .core_key(core_key), .core_iv(core_iv),
        .core_ctr(core_ctr), .core_ready(core_ready), .core_data_out(core_data_out),
        .core_data_out_valid(core_data_out_valid)
    );

    int checks = 0, errors = 0;
    int cyc = 0, n_init = 0, n_next = 0, n_done = 0, n_stall = 0, stab_viol = 0;
    int done_cyc = 0, last_cyc = 0, first_vld_cyc = 0, cv_cyc = 0;
    int core_lat = 1, cm_cnt = 0;
    logic [63:0]  cm_ctr;
    logic [255:0] cm_key;
    logic         prev_stall = 1'b0, prev_vld = 1'b0;
    logic [31:0]  prev_word = '0;
    logic [31:0]  words_q[$];
    logic         last_q[$];
    logic [63:0]  ctr_log[$];
    bit           rand_ready = 1'b0, inj_valid = 1'b0;

    localparam logic [255:0] K1 = {4{64'h0123456789abcdef}};
    localparam logic [255:0] K2 = {8{32'h5a5a1234}};
    localparam logic [255:0] K3 = {8{32'h0badf00d}};
    localparam logic [63:0]  IV1 = 64'hdeadbeefcafebabe;

    function automatic logic [31:0] mk_word(logic [255:0] k, logic [63:0] c, int i);
        return (k[31:0] + c[31:0] * 32'd3 + c[63:32] * 32'd5) ^ (32'(i) * 32'h01000193);
    endfunction

    function automatic logic [511:0] mk_block(logic [255:0] k, logic [63:0] c);
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = mk_word(k, c, i);
        return b;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        ks.ks_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 ks.ks_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Core stand-in plus stream/handshake monitor, all sampled on the falling edge.
    initial begin
        core_data_out_valid = 1'b0;
        core_data_out = '0;
        forever begin
            @(negedge clk);
            cyc++;
            core_data_out_valid = 1'b0;
            if (cm_cnt > 0) begin
                cm_cnt--;
                if (cm_cnt == 0) begin
                    core_data_out = mk_block(cm_key, cm_ctr);
                    core_data_out_valid = 1'b1;
                    cv_cyc = cyc;
                end
            end
            if (inj_valid) begin
                core_data_out = {16{32'hfeedface}};
                core_data_out_valid = 1'b1;
            end
            if (core_init) n_init++;
            if (core_next) begin
                n_next++;
                ctr_log.push_back(core_ctr);
                cm_ctr = core_ctr;
                cm_key = core_key;
                cm_cnt = core_lat;
            end
            if (done) begin n_done++; done_cyc = cyc; end
            if (ks.ks_valid && !prev_vld) first_vld_cyc = cyc;
            if (prev_stall && !(ks.ks_valid && ks.ks_word == prev_word)) stab_viol++;
            prev_stall = reset_n && ks.ks_valid && !ks.ks_ready;
            if (prev_stall) n_stall++;
            prev_word = ks.ks_word;
            prev_vld = ks.ks_valid;
            if (ks.ks_valid && ks.ks_ready) begin
                words_q.push_back(ks.ks_word);
                last_q.push_back(ks.ks_last);
                if (ks.ks_last) last_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic run(input logic [255:0] k, input logic [63:0] c, input int nb);
        @(posedge clk); #1;
        key = k; iv = IV1; ctr_start = c; num_blocks = 16'(nb); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        int k = 0;
        while (n_done == d0 && k < budget) begin @(negedge clk); k++; end
        repeat (3) @(negedge clk);
        chk({tag, "_done_cnt"}, 256'(n_done - d0), 256'd1);
    endtask

    task automatic chk_stream(input string tag, input logic [255:0] k, input logic [63:0] c,
                              input int nb, input int w0, input int l0);
        int bad_w = 0, bad_l = 0, bad_c = 0;
        chk({tag, "_nwords"}, 256'(words_q.size() - w0), 256'(nb * 16));
        chk({tag, "_nctr"}, 256'(ctr_log.size() - l0), 256'(nb));
        for (int b = 0; b < nb; b++) begin
            if (l0 + b < ctr_log.size() && ctr_log[l0 + b] !== c + 64'(b)) bad_c++;
            for (int i = 0; i < 16; i++) begin
                int idx = w0 + b * 16 + i;
                if (idx < words_q.size()) begin
                    if (words_q[idx] !== mk_word(k, c + 64'(b), i)) bad_w++;
                    if (last_q[idx] !== (b == nb - 1 && i == 15)) bad_l++;
                end
            end
        end
        chk({tag, "_bad_words"}, 256'(bad_w), 256'd0);
        chk({tag, "_bad_last"}, 256'(bad_l), 256'd0);
        chk({tag, "_bad_ctr"}, 256'(bad_c), 256'd0);
    endtask

    initial begin
        int w0, l0, i0, x0, d0, s0, v0, k;
        reset_n = 1'b0; start = 1'b0; key = '0; iv = '0; ctr_start = '0; num_blocks = '0;
        core_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_done", 256'(done), 256'd0);
        chk("rst_ks_valid", 256'(ks.ks_valid), 256'd0);
        chk("rst_ks_word", 256'(ks.ks_word), 256'd0);
        chk("rst_ks_last", 256'(ks.ks_last), 256'd0);
        chk("rst_core_init", 256'(core_init), 256'd0);
        chk("rst_core_key", core_key, 256'd0);
        chk("rst_core_ctr", 256'(core_ctr), 256'd0);
        reset_n = 1'b1;

        // Single block, no backpressure.
        w0 = words_q.size(); l0 = ctr_log.size(); i0 = n_init; x0 = n_next; d0 = n_done;
        run(K1, 64'd0, 1);
        @(negedge clk);
        chk("t1_init_lat", 256'(core_init), 256'd1);
        chk("t1_busy", 256'(busy), 256'd1);
        chk("t1_core_key", core_key, K1);
        chk("t1_core_iv", 256'(core_iv), 256'(IV1));
        wait_done("t1", d0, 200);
        chk("t1_inits", 256'(n_init - i0), 256'd1);
        chk("t1_nexts", 256'(n_next - x0), 256'd1);
        chk_stream("t1", K1, 64'd0, 1, w0, l0);
        chk("t1_done_gap", 256'(done_cyc - last_cyc), 256'd1);
        chk("t1_first_vld_lat", 256'(first_vld_cyc - cv_cyc), 256'd1);
        chk("t1_busy_end", 256'(busy), 256'd0);

        // Ten blocks, slower core.
        core_lat = 4;
        w0 = words_q.size(); l0 = ctr_log.size(); i0 = n_init; d0 = n_done;
        run(K2, 64'd0, 10);
        wait_done("t2", d0, 2000);
        chk("t2_inits", 256'(n_init - i0), 256'd10);
        chk_stream("t2", K2, 64'd0, 10, w0, l0);

        // Counter wrap.
        core_lat = 2;
        w0 = words_q.size(); l0 = ctr_log.size(); d0 = n_done;
        run(K1, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        wait_done("t3", d0, 500);
        chk_stream("t3", K1, 64'hFFFF_FFFF_FFFF_FFFF, 2, w0, l0);
        chk("t3_wrap_ctr", 256'(ctr_log[l0 + 1]), 256'd0);

        // Random ks_ready stalls.
        rand_ready = 1'b1;
        w0 = words_q.size(); l0 = ctr_log.size(); d0 = n_done; s0 = n_stall; v0 = stab_viol;
        run(K3, 64'd5, 3);
        wait_done("t4", d0, 3000);
        rand_ready = 1'b0;
        chk_stream("t4", K3, 64'd5, 3, w0, l0);
        chk("t4_stable", 256'(stab_viol - v0), 256'd0);
        chk("t4_stalls_seen", 256'((n_stall - s0) > 0), 256'd1);

        // Zero blocks.
        w0 = words_q.size(); i0 = n_init; x0 = n_next; d0 = n_done;
        run(K2, 64'd9, 0);
        wait_done("t5", d0, 20);
        chk("t5_inits", 256'(n_init - i0), 256'd0);
        chk("t5_nexts", 256'(n_next - x0), 256'd0);
        chk("t5_words", 256'(words_q.size() - w0), 256'd0);
        chk("t5_busy", 256'(busy), 256'd0);

        // Stray start while busy, then reset mid-drain.
        core_lat = 1;
        w0 = words_q.size();
        run(K2, 64'd100, 4);
        k = 0;
        while (words_q.size() < w0 + 20 && k < 400) begin @(negedge clk); k++; end
        chk("t6_reached_drain", 256'(words_q.size() >= w0 + 20), 256'd1);
        run(K3, 64'd999, 1);
        @(negedge clk);
        chk("t6_key_kept", core_key, K2);
        chk("t6_ctr_kept", 256'(core_ctr), 256'd101);
        chk("t6_busy", 256'(busy), 256'd1);
        d0 = n_done;
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        chk("t6_rst_busy", 256'(busy), 256'd0);
        chk("t6_rst_valid", 256'(ks.ks_valid), 256'd0);
        chk("t6_rst_ctr", 256'(core_ctr), 256'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1 inj_valid = 1'b1;
        @(posedge clk); #1 inj_valid = 1'b0;
        w0 = words_q.size();
        repeat (30) @(negedge clk);
        chk("t6_no_done", 256'(n_done - d0), 256'd0);
        chk("t6_idle", 256'(busy), 256'd0);
        chk("t6_stray_valid", 256'(words_q.size() - w0), 256'd0);

        // Recovery after reset.
        w0 = words_q.size(); l0 = ctr_log.size(); d0 = n_done;
        run(K1, 64'd7, 1);
        wait_done("t7", d0, 200);
        chk_stream("t7", K1, 64'd7, 1, w0, l0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
